// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small byte FIFO.
// Bytes arrive over a valid/ready handshake, are buffered in a circular
// FIFO and serialised LSB first as 8N1, or 8E1/8O1 when PARITY is 1/2.
// Frames follow each other with no idle gap while the FIFO holds data.
//
// Ports:
//   clk        system clock, all state updates on its rising edge
//   reset      synchronous, active-high reset
//   tx_data    byte to send
//   tx_valid   tx_data is valid this cycle
//   tx_ready   FIFO can accept a byte (not full)
//   tx_serial  serial line, idle high, registered
//   tx_busy    frame on the line or FIFO non-empty (registered)
//   tx_done    one-cycle pulse at the end of each stop bit
//   fifo_count bytes currently buffered
module uart_tx_fifo #(
    parameter int FREQ       = 100000000,
    parameter int BAUDRATE   = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = FREQ / BAUDRATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 32'sd1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for a byte: even mode is the XOR of the data, odd its inverse.
    function automatic logic parity_of(input logic [7:0] d);
        if (PARITY == 32'sd2) begin
            return ~(^d);
        end else begin
            return ^d;
        end
    endfunction

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic          r_serial;
    logic          r_busy;
    logic          r_done;

    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic [7:0]    w_head;

    assign tx_ready   = (r_count != FULL_COUNT);
    assign w_head     = r_mem[r_rd_ptr];
    assign tx_serial  = r_serial;
    assign tx_busy    = r_busy;
    assign tx_done    = r_done;
    assign fifo_count = r_count;

    // Handshake and pop qualification; a pop only uses the registered count,
    // so a byte is never popped in the same cycle it is pushed.
    always_comb begin
        w_push    = tx_valid && tx_ready;
        w_bit_end = (r_bit_cnt == {CW{1'b0}});
        w_pop     = 1'b0;
        if (r_count != {(AW + 1){1'b0}}) begin
            if (r_state == S_IDLE) begin
                w_pop = 1'b1;
            end else if ((r_state == S_STOP) && w_bit_end) begin
                w_pop = 1'b1;
            end else begin
                w_pop = 1'b0;
            end
        end else begin
            w_pop = 1'b0;
        end
    end

    // FIFO storage; no reset needed since the pointers qualify the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth makes pointers wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Busy flag, registered from the current state and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) || (r_count != {(AW + 1){1'b0}});
        end
    end

    // Frame sequencer. Shift register and parity are captured at pop time so
    // bytes pushed later cannot disturb the frame on the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= {CW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_parity  <= parity_of(w_head);
                        r_bit_cnt <= CNT_RELOAD;
                        r_serial  <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= CNT_RELOAD;
                        r_bit_idx <= 3'd0;
                        r_serial  <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_state   <= S_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= CNT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            if (PARITY != 32'sd0) begin
                                r_serial <= r_parity;
                                r_state  <= S_PARITY;
                            end else begin
                                r_serial <= 1'b1;
                                r_state  <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_serial  <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= CNT_RELOAD;
                        r_serial  <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_done <= 1'b1;
                        // Next byte waiting: start bit follows immediately.
                        if (w_pop) begin
                            r_shift   <= w_head;
                            r_parity  <= parity_of(w_head);
                            r_bit_cnt <= CNT_RELOAD;
                            r_serial  <= 1'b0;
                            r_state   <= S_START;
                        end else begin
                            r_serial <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CW'(1);
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at DIV=16.
// Three instances share clock, reset and data: parity none, even and odd.
module tb_uart_tx_fifo;
    localparam int FREQ  = 160;
    localparam int BAUD  = 10;
    localparam int DIV   = 16;
    localparam int LIMIT = 4000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic       rdy0, rdy1, rdy2;
    logic       ser0, ser1, ser2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [2:0] cnt0, cnt1, cnt2;

    int cyc = 0;
    int done_cnt0 = 0;
    int n_checks = 0;
    int n_errors = 0;

    uart_tx_fifo #(.FREQ(FREQ), .BAUDRATE(BAUD), .FIFO_DEPTH(4), .PARITY(0)) u_dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v0), .tx_ready(rdy0),
        .tx_serial(ser0), .tx_busy(busy0), .tx_done(done0), .fifo_count(cnt0));
    uart_tx_fifo #(.FREQ(FREQ), .BAUDRATE(BAUD), .FIFO_DEPTH(4), .PARITY(1)) u_dut_even (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v1), .tx_ready(rdy1),
        .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1), .fifo_count(cnt1));
    uart_tx_fifo #(.FREQ(FREQ), .BAUDRATE(BAUD), .FIFO_DEPTH(4), .PARITY(2)) u_dut_odd (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v2), .tx_ready(rdy2),
        .tx_serial(ser2), .tx_busy(busy2), .tx_done(done2), .fifo_count(cnt2));

    always #5 clk = ~clk;

    // Edge counter used to timestamp events.
    always @(posedge clk) cyc <= cyc + 1;

    // Count tx_done pulses of the no-parity instance.
    always @(negedge clk) if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        case (sel)
            0:       return ser0;
            1:       return ser1;
            default: return ser2;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Synchronous reset for two edges; returns at a negedge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Push one byte into the parity-none instance, holding valid until
    // accepted. Called and returns at a negedge. acc = edge that took it.
    task automatic push0(input logic [7:0] b, output int acc, output int bad_full);
        int g;
        g = 0; bad_full = 0;
        tx_data = b; v0 = 1'b1;
        while (rdy0 !== 1'b1 && g < LIMIT) begin
            if (cnt0 !== 3'd4) bad_full++;
            @(negedge clk);
            g++;
        end
        if (g >= LIMIT) check_eq("push_timeout", 32'(g), 32'(LIMIT - 1));
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        acc = cyc;
    endtask

    // Behavioural receiver sampling mid-bit; st = start edge, dn = done edge.
    task automatic rx_frame(input int sel, input bit has_par, output logic [7:0] b,
                            output logic p, output logic ok, output int st, output int dn);
        int g;
        g = 0; ok = 1'b1; b = 8'h00; p = 1'b0;
        while (line_of(sel) !== 1'b0 && g < LIMIT) begin @(negedge clk); g++; end
        if (g >= LIMIT) ok = 1'b0;
        st = cyc;
        repeat (DIV / 2) @(negedge clk);
        if (line_of(sel) !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = line_of(sel);
        end
        if (has_par) begin
            repeat (DIV) @(negedge clk);
            p = line_of(sel);
        end
        repeat (DIV) @(negedge clk);
        if (line_of(sel) !== 1'b1) ok = 1'b0;
        g = 0;
        while (done_of(sel) !== 1'b1 && g < DIV) begin @(negedge clk); g++; end
        dn = cyc;
    endtask

    logic [7:0] rb [16];
    logic       rok [16];
    int         rst_c [16];
    int         rdn [16];
    logic [7:0] burst [6];
    logic [7:0] rnd [16];
    logic [7:0] b1, b2, d55;
    logic       p1, p2, ok1, ok2, e;
    int acc_first, acc, acc6, bad, bad_full, dn, st1, st2, dn1, dn2, base;

    initial begin
        burst[0] = 8'hA3; burst[1] = 8'h0F; burst[2] = 8'hFF;
        burst[3] = 8'h00; burst[4] = 8'h81; burst[5] = 8'h5A;

        // Reset state
        do_reset();
        check_eq("rst_serial", ser0, 1'b1);
        check_eq("rst_ready", rdy0, 1'b1);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_done", done0, 1'b0);
        check_eq("rst_count", cnt0, 3'd0);
        check_eq("rst_ready_par", {rdy1, rdy2}, 2'b11);

        // Single frame 0x55: exact waveform, latency, done and busy timing
        d55 = 8'h55;
        push0(d55, acc, bad_full);
        check_eq("lat_count", cnt0, 3'd1);
        check_eq("lat_serial_high", ser0, 1'b1);
        @(negedge clk);
        check_eq("lat_start", ser0, 1'b0);
        bad = 0; dn = 0;
        for (int k = 0; k < 10 * DIV; k++) begin
            if (k < DIV) e = 1'b0;
            else if (k < 9 * DIV) e = d55[(k / DIV) - 1];
            else e = 1'b1;
            if (ser0 !== e) bad++;
            if (done0 === 1'b1) dn++;
            @(negedge clk);
        end
        check_eq("wave_55", 32'(bad), 32'd0);
        check_eq("done_early", 32'(dn), 32'd0);
        check_eq("done_at_160", done0, 1'b1);
        check_eq("busy_at_160", busy0, 1'b1);
        @(negedge clk);
        check_eq("done_pulse_len", done0, 1'b0);
        check_eq("busy_fall_161", busy0, 1'b0);

        // Burst of five plus a sixth byte held while full
        do_reset();
        base = done_cnt0;
        fork
            begin
                push0(burst[0], acc_first, bad_full);
                for (int i = 1; i < 5; i++) push0(burst[i], acc, bad_full);
                check_eq("full_count", cnt0, 3'd4);
                check_eq("full_ready", rdy0, 1'b0);
                push0(burst[5], acc6, bad_full);
                check_eq("full_hold_count", 32'(bad_full), 32'd0);
                check_eq("held_accept_edge", 32'(acc6 - acc_first), 32'd162);
            end
            begin
                for (int i = 0; i < 6; i++) rx_frame(0, 1'b0, rb[i], p1, rok[i], rst_c[i], rdn[i]);
            end
        join
        check_eq("burst_latency", 32'(rst_c[0] - acc_first), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("burst_byte%0d", i), rb[i], burst[i]);
            check_eq($sformatf("burst_frame%0d", i), rok[i], 1'b1);
            check_eq($sformatf("burst_len%0d", i), 32'(rdn[i] - rst_c[i]), 32'd160);
            if (i > 0) check_eq($sformatf("burst_gap%0d", i), 32'(rst_c[i] - rst_c[i-1]), 32'd160);
        end
        repeat (5) @(negedge clk);
        check_eq("burst_done_cnt", 32'(done_cnt0 - base), 32'd6);
        check_eq("burst_idle_busy", busy0, 1'b0);
        check_eq("burst_idle_count", cnt0, 3'd0);

        // Parity even and odd on 0x07, 176-cycle frames
        do_reset();
        tx_data = 8'h07; v1 = 1'b1; v2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0; v2 = 1'b0;
        fork
            rx_frame(1, 1'b1, b1, p1, ok1, st1, dn1);
            rx_frame(2, 1'b1, b2, p2, ok2, st2, dn2);
        join
        check_eq("even_byte", b1, 8'h07);
        check_eq("even_parity", p1, 1'b1);
        check_eq("even_frame", ok1, 1'b1);
        check_eq("even_len", 32'(dn1 - st1), 32'd176);
        check_eq("odd_byte", b2, 8'h07);
        check_eq("odd_parity", p2, 1'b0);
        check_eq("odd_frame", ok2, 1'b1);
        check_eq("odd_len", 32'(dn2 - st2), 32'd176);
        repeat (3) @(negedge clk);
        check_eq("par_idle", {busy1, busy2, cnt1, cnt2}, 8'h00);

        // Reset mid-DATA with two bytes buffered
        do_reset();
        push0(8'h11, acc, bad_full);
        push0(8'h22, acc, bad_full);
        push0(8'h33, acc, bad_full);
        repeat (40) @(negedge clk);
        check_eq("pre_rst_count", cnt0, 3'd2);
        check_eq("pre_rst_busy", busy0, 1'b1);
        base = done_cnt0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_serial", ser0, 1'b1);
        check_eq("midrst_count", cnt0, 3'd0);
        check_eq("midrst_busy", busy0, 1'b0);
        check_eq("midrst_done", done0, 1'b0);
        bad = 0;
        repeat (200) begin
            if (ser0 !== 1'b1) bad++;
            @(negedge clk);
        end
        check_eq("midrst_line_idle", 32'(bad), 32'd0);
        check_eq("midrst_no_done", 32'(done_cnt0 - base), 32'd0);
        fork
            push0(8'h3C, acc, bad_full);
            rx_frame(0, 1'b0, b1, p1, ok1, st1, dn1);
        join
        check_eq("post_rst_byte", b1, 8'h3C);
        check_eq("post_rst_frame", ok1, 1'b1);

        // Loopback of 16 random bytes
        for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom_range(0, 255));
        repeat (4) @(negedge clk);
        base = done_cnt0;
        fork
            begin
                for (int i = 0; i < 16; i++) push0(rnd[i], acc, bad_full);
            end
            begin
                for (int i = 0; i < 16; i++) rx_frame(0, 1'b0, rb[i], p1, rok[i], rst_c[i], rdn[i]);
            end
        join
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("loop_byte%0d", i), {rok[i], rb[i]}, {1'b1, rnd[i]});
        end
        repeat (5) @(negedge clk);
        check_eq("loop_done_cnt", 32'(done_cnt0 - base), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
